// File: rtl/id_ras.sv
`default_nettype none
// ============================================================================
// Module : id_ras
// Brief  : Registered, handshaked instruction decoder with a circular
//          hardware return-address stack and a two-cycle LDAR sequence.
// Rev    : 1.0  initial release
// ============================================================================
module id_ras #(
  parameter int WIDTH           = 8,
  parameter int PC_WIDTH        = 8,
  parameter int ALU_INSTR_WIDTH = 4,
  parameter int REG_F_SEL_SIZE  = 4,
  parameter int IN_B_SEL_SIZE   = 2,
  parameter int RAS_DEPTH       = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   instr,
  input  logic [WIDTH-1:0]                   arg,
  input  logic [PC_WIDTH-1:0]                pc,
  input  logic                               z_flag,
  output logic                               out_valid,
  output logic [ALU_INSTR_WIDTH-1:0]         alu_op,
  output logic [WIDTH-1:0]                   imm,
  output logic [IN_B_SEL_SIZE-1:0]           in_b_sel,
  output logic [REG_F_SEL_SIZE-1:0]          reg_f_sel,
  output logic                               en_reg_f,
  output logic [WIDTH-1:0]                   d_mem_addr,
  output logic                               d_mem_addr_mode,
  output logic                               en_d_mem,
  output logic                               en_acc,
  output logic                               pc_rst,
  output logic                               pc_ld,
  output logic [1:0]                         jmp_mode,
  output logic [PC_WIDTH-1:0]                jmp_target,
  output logic                               base_reg_ld,
  output logic [WIDTH-1:0]                   base_reg_data,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ras_ovf,
  output logic                               ras_unf
);

  localparam int c_CW = $clog2(RAS_DEPTH + 1);
  localparam int c_PW = $clog2(RAS_DEPTH);

  localparam logic [WIDTH-1:0] c_OP_LD   = WIDTH'(8'h01);
  localparam logic [WIDTH-1:0] c_OP_LDI  = WIDTH'(8'h02);
  localparam logic [WIDTH-1:0] c_OP_LDR  = WIDTH'(8'h03);
  localparam logic [WIDTH-1:0] c_OP_ST   = WIDTH'(8'h04);
  localparam logic [WIDTH-1:0] c_OP_STR  = WIDTH'(8'h05);
  localparam logic [WIDTH-1:0] c_OP_LDAR = WIDTH'(8'h06);
  localparam logic [WIDTH-1:0] c_OP_BAR  = WIDTH'(8'h07);
  localparam logic [WIDTH-1:0] c_OP_JMP  = WIDTH'(8'h40);
  localparam logic [WIDTH-1:0] c_OP_JMPO = WIDTH'(8'h41);
  localparam logic [WIDTH-1:0] c_OP_JZ   = WIDTH'(8'h42);
  localparam logic [WIDTH-1:0] c_OP_JZO  = WIDTH'(8'h43);
  localparam logic [WIDTH-1:0] c_OP_CALL = WIDTH'(8'h44);
  localparam logic [WIDTH-1:0] c_OP_RET  = WIDTH'(8'h45);
  localparam logic [WIDTH-1:0] c_OP_RST  = WIDTH'(8'h46);

  localparam logic [IN_B_SEL_SIZE-1:0] c_B_IMM = IN_B_SEL_SIZE'(0);
  localparam logic [IN_B_SEL_SIZE-1:0] c_B_REG = IN_B_SEL_SIZE'(1);
  localparam logic [IN_B_SEL_SIZE-1:0] c_B_MEM = IN_B_SEL_SIZE'(2);
  localparam logic [c_CW-1:0]          c_FULL  = c_CW'(RAS_DEPTH);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_LDAR2 = 1'b1} state_t;

  state_t                      r_state, w_state_nxt;
  logic [PC_WIDTH-1:0]         r_ras [RAS_DEPTH];
  logic [c_PW-1:0]             r_sp;
  logic [c_CW-1:0]             r_ras_count;
  logic                        r_ovf, r_unf;
  logic [REG_F_SEL_SIZE-1:0]   r_ldar_sel;

  logic                        w_accept, w_full, w_empty;
  logic [c_PW-1:0]             w_top_idx, w_sp_inc;
  logic [PC_WIDTH-1:0]         w_ret_addr;
  logic [WIDTH-5:0]            w_grp;
  logic                        w_push, w_pop, w_clear, w_ovf_set, w_unf_set;

  logic                        w_out_valid, w_en_reg_f, w_d_mem_addr_mode, w_en_d_mem;
  logic                        w_en_acc, w_pc_rst, w_pc_ld, w_base_reg_ld;
  logic [ALU_INSTR_WIDTH-1:0]  w_alu_op;
  logic [WIDTH-1:0]            w_imm, w_d_mem_addr, w_base_reg_data;
  logic [IN_B_SEL_SIZE-1:0]    w_in_b_sel;
  logic [REG_F_SEL_SIZE-1:0]   w_reg_f_sel;
  logic [1:0]                  w_jmp_mode;
  logic [PC_WIDTH-1:0]         w_jmp_target;

  assign in_ready   = (r_state == S_RUN);
  assign w_accept   = in_valid && in_ready;
  assign w_full     = (r_ras_count == c_FULL);
  assign w_empty    = (r_ras_count == '0);
  assign w_ret_addr = pc + PC_WIDTH'(1);
  assign w_grp      = instr[WIDTH-1:4];
  // The stack pointer names the next free slot and wraps, so a full push overwrites the oldest entry.
  assign w_top_idx  = (r_sp == '0) ? c_PW'(RAS_DEPTH - 1) : r_sp - c_PW'(1);
  assign w_sp_inc   = (r_sp == c_PW'(RAS_DEPTH - 1)) ? '0 : r_sp + c_PW'(1);
  assign ras_count  = r_ras_count;
  assign ras_ovf    = r_ovf;
  assign ras_unf    = r_unf;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_out_valid       = 1'b0;
    w_alu_op          = '1;
    w_imm             = '0;
    w_in_b_sel        = c_B_MEM;
    w_reg_f_sel       = '0;
    w_en_reg_f        = 1'b0;
    w_d_mem_addr      = '0;
    w_d_mem_addr_mode = 1'b0;
    w_en_d_mem        = 1'b0;
    w_en_acc          = 1'b0;
    w_pc_rst          = 1'b0;
    w_pc_ld           = 1'b0;
    w_jmp_mode        = 2'b00;
    w_jmp_target      = '0;
    w_base_reg_ld     = 1'b0;
    w_base_reg_data   = '0;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_clear           = 1'b0;
    w_ovf_set         = 1'b0;
    w_unf_set         = 1'b0;
    if (r_state == S_LDAR2) begin
      w_out_valid       = 1'b1;
      w_reg_f_sel       = r_ldar_sel;
      w_d_mem_addr_mode = 1'b1;
      w_en_acc          = 1'b1;
      w_alu_op          = c_OP_LDAR[ALU_INSTR_WIDTH-1:0];
      w_state_nxt       = S_RUN;
    end else if (w_accept) begin
      w_out_valid = 1'b1;
      case (instr)
        c_OP_LD: begin
          w_alu_op = instr[ALU_INSTR_WIDTH-1:0]; w_in_b_sel = c_B_MEM;
          w_d_mem_addr = arg; w_en_acc = 1'b1;
        end
        c_OP_LDI: begin
          w_alu_op = instr[ALU_INSTR_WIDTH-1:0]; w_in_b_sel = c_B_IMM;
          w_imm = arg; w_en_acc = 1'b1;
        end
        c_OP_LDR: begin
          w_alu_op = instr[ALU_INSTR_WIDTH-1:0]; w_in_b_sel = c_B_REG;
          w_reg_f_sel = arg[REG_F_SEL_SIZE-1:0]; w_en_acc = 1'b1;
        end
        c_OP_ST:   begin w_d_mem_addr = arg; w_en_d_mem = 1'b1; end
        c_OP_STR:  begin w_reg_f_sel = arg[REG_F_SEL_SIZE-1:0]; w_en_reg_f = 1'b1; end
        c_OP_LDAR: begin
          w_reg_f_sel = arg[REG_F_SEL_SIZE-1:0]; w_d_mem_addr_mode = 1'b1;
          w_state_nxt = S_LDAR2;
        end
        c_OP_BAR:  begin w_base_reg_ld = 1'b1; w_base_reg_data = arg; end
        c_OP_JMP:  begin w_pc_ld = 1'b1; w_jmp_target = arg[PC_WIDTH-1:0]; end
        c_OP_JMPO: begin w_pc_ld = 1'b1; w_jmp_mode = 2'b01; w_jmp_target = arg[PC_WIDTH-1:0]; end
        c_OP_JZ:   if (z_flag) begin w_pc_ld = 1'b1; w_jmp_target = arg[PC_WIDTH-1:0]; end
        c_OP_JZO:  if (z_flag) begin
          w_pc_ld = 1'b1; w_jmp_mode = 2'b01; w_jmp_target = arg[PC_WIDTH-1:0];
        end
        c_OP_CALL: begin
          w_push = 1'b1; w_ovf_set = w_full;
          w_pc_ld = 1'b1; w_jmp_target = arg[PC_WIDTH-1:0];
        end
        c_OP_RET: begin
          if (w_empty) w_unf_set = 1'b1;
          else begin
            w_pop = 1'b1; w_pc_ld = 1'b1; w_jmp_mode = 2'b11;
            w_jmp_target = r_ras[w_top_idx];
          end
        end
        c_OP_RST: begin w_pc_rst = 1'b1; w_clear = 1'b1; end
        default: begin
          if (w_grp == (WIDTH-4)'(1)) begin
            w_alu_op = instr[ALU_INSTR_WIDTH-1:0]; w_in_b_sel = c_B_IMM;
            w_imm = arg; w_en_acc = 1'b1;
          end else if (w_grp == (WIDTH-4)'(2)) begin
            w_alu_op = instr[ALU_INSTR_WIDTH-1:0]; w_in_b_sel = c_B_REG;
            w_reg_f_sel = arg[REG_F_SEL_SIZE-1:0]; w_en_acc = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && instr == c_OP_LDAR) r_ldar_sel <= arg[REG_F_SEL_SIZE-1:0];
    if (rst_n && w_push)                r_ras[r_sp] <= w_ret_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp <= '0; r_ras_count <= '0; r_ovf <= 1'b0; r_unf <= 1'b0;
    end else begin
      if (w_clear) begin
        r_sp <= '0; r_ras_count <= '0;
      end else if (w_push) begin
        r_sp <= w_sp_inc;
        if (!w_full) r_ras_count <= r_ras_count + c_CW'(1);
      end else if (w_pop) begin
        r_sp <= w_top_idx;
        r_ras_count <= r_ras_count - c_CW'(1);
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0; alu_op <= '1; imm <= '0; in_b_sel <= c_B_MEM;
      reg_f_sel <= '0; en_reg_f <= 1'b0; d_mem_addr <= '0; d_mem_addr_mode <= 1'b0;
      en_d_mem <= 1'b0; en_acc <= 1'b0; pc_rst <= 1'b0; pc_ld <= 1'b0;
      jmp_mode <= 2'b00; jmp_target <= '0; base_reg_ld <= 1'b0; base_reg_data <= '0;
    end else begin
      out_valid <= w_out_valid; alu_op <= w_alu_op; imm <= w_imm; in_b_sel <= w_in_b_sel;
      reg_f_sel <= w_reg_f_sel; en_reg_f <= w_en_reg_f; d_mem_addr <= w_d_mem_addr;
      d_mem_addr_mode <= w_d_mem_addr_mode; en_d_mem <= w_en_d_mem; en_acc <= w_en_acc;
      pc_rst <= w_pc_rst; pc_ld <= w_pc_ld; jmp_mode <= w_jmp_mode; jmp_target <= w_jmp_target;
      base_reg_ld <= w_base_reg_ld; base_reg_data <= w_base_reg_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ras.sv
`default_nettype none
// ============================================================================
// Module : tb_id_ras
// Brief  : Directed and randomized checks of id_ras against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_id_ras;
  localparam int DEPTH = 4;

  localparam logic [7:0] OP_LD = 8'h01, OP_LDI = 8'h02, OP_LDR = 8'h03, OP_ST = 8'h04;
  localparam logic [7:0] OP_STR = 8'h05, OP_LDAR = 8'h06, OP_BAR = 8'h07;
  localparam logic [7:0] OP_JMP = 8'h40, OP_JMPO = 8'h41, OP_JZ = 8'h42, OP_JZO = 8'h43;
  localparam logic [7:0] OP_CALL = 8'h44, OP_RET = 8'h45, OP_RST = 8'h46;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, z_flag = 1'b0;
  logic [7:0] instr = '0, arg = '0, pc = '0;
  logic in_ready, out_valid, en_reg_f, d_mem_addr_mode, en_d_mem, en_acc;
  logic pc_rst, pc_ld, base_reg_ld, ras_ovf, ras_unf;
  logic [3:0] alu_op, reg_f_sel;
  logic [7:0] imm, d_mem_addr, jmp_target, base_reg_data;
  logic [1:0] in_b_sel, jmp_mode;
  logic [2:0] ras_count;

  always #5 clk = ~clk;

  id_ras #(.RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .arg(arg), .pc(pc), .z_flag(z_flag), .out_valid(out_valid),
    .alu_op(alu_op), .imm(imm), .in_b_sel(in_b_sel), .reg_f_sel(reg_f_sel),
    .en_reg_f(en_reg_f), .d_mem_addr(d_mem_addr), .d_mem_addr_mode(d_mem_addr_mode),
    .en_d_mem(en_d_mem), .en_acc(en_acc), .pc_rst(pc_rst), .pc_ld(pc_ld),
    .jmp_mode(jmp_mode), .jmp_target(jmp_target), .base_reg_ld(base_reg_ld),
    .base_reg_data(base_reg_data), .ras_count(ras_count), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stack is a plain queue, newest entry at the back.
  logic [7:0] ras_q[$];
  bit         live = 0, pend = 0, m_ovf = 0, m_unf = 0;
  logic [3:0] pend_sel;
  logic       e_valid, e_enrf, e_dmm, e_endm, e_acc, e_pcr, e_pcld, e_bld, e_ready;
  logic [3:0] e_alu, e_rsel;
  logic [7:0] e_imm, e_dma, e_tgt, e_bd;
  logic [1:0] e_bsel, e_jm;

  always @(posedge clk) begin
    e_valid = 0; e_alu = 4'hF; e_imm = 0; e_bsel = 2'b10; e_rsel = 0; e_enrf = 0;
    e_dma = 0; e_dmm = 0; e_endm = 0; e_acc = 0; e_pcr = 0; e_pcld = 0; e_jm = 0;
    e_tgt = 0; e_bld = 0; e_bd = 0;
    if (!rst_n) begin
      ras_q.delete(); m_ovf = 0; m_unf = 0; pend = 0;
    end else if (pend) begin
      e_valid = 1; e_rsel = pend_sel; e_dmm = 1; e_acc = 1; e_alu = OP_LDAR[3:0];
      pend = 0;
    end else if (in_valid) begin
      e_valid = 1;
      if (instr[7:4] == 4'h1) begin
        e_alu = instr[3:0]; e_bsel = 2'b00; e_imm = arg; e_acc = 1;
      end else if (instr[7:4] == 4'h2) begin
        e_alu = instr[3:0]; e_bsel = 2'b01; e_rsel = arg[3:0]; e_acc = 1;
      end else begin
        case (instr)
          OP_LD:   begin e_alu = instr[3:0]; e_bsel = 2'b10; e_dma = arg; e_acc = 1; end
          OP_LDI:  begin e_alu = instr[3:0]; e_bsel = 2'b00; e_imm = arg; e_acc = 1; end
          OP_LDR:  begin e_alu = instr[3:0]; e_bsel = 2'b01; e_rsel = arg[3:0]; e_acc = 1; end
          OP_ST:   begin e_dma = arg; e_endm = 1; end
          OP_STR:  begin e_rsel = arg[3:0]; e_enrf = 1; end
          OP_LDAR: begin e_rsel = arg[3:0]; e_dmm = 1; pend = 1; pend_sel = arg[3:0]; end
          OP_BAR:  begin e_bld = 1; e_bd = arg; end
          OP_JMP:  begin e_pcld = 1; e_tgt = arg; end
          OP_JMPO: begin e_pcld = 1; e_jm = 2'b01; e_tgt = arg; end
          OP_JZ:   if (z_flag) begin e_pcld = 1; e_tgt = arg; end
          OP_JZO:  if (z_flag) begin e_pcld = 1; e_jm = 2'b01; e_tgt = arg; end
          OP_CALL: begin
            logic [7:0] ra;
            ra = pc + 8'd1;
            ras_q.push_back(ra);
            if (ras_q.size() > DEPTH) begin void'(ras_q.pop_front()); m_ovf = 1; end
            e_pcld = 1; e_tgt = arg;
          end
          OP_RET:
            if (ras_q.size() == 0) m_unf = 1;
            else begin e_tgt = ras_q.pop_back(); e_jm = 2'b11; e_pcld = 1; end
          OP_RST:  begin e_pcr = 1; ras_q.delete(); end
          default: ;
        endcase
      end
    end
    e_ready = !pend;
    live = 1;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", in_ready, e_ready);       chk("out_valid", out_valid, e_valid);
      chk("alu_op", alu_op, e_alu);             chk("imm", imm, e_imm);
      chk("in_b_sel", in_b_sel, e_bsel);        chk("reg_f_sel", reg_f_sel, e_rsel);
      chk("en_reg_f", en_reg_f, e_enrf);        chk("d_mem_addr", d_mem_addr, e_dma);
      chk("d_mem_addr_mode", d_mem_addr_mode, e_dmm);
      chk("en_d_mem", en_d_mem, e_endm);        chk("en_acc", en_acc, e_acc);
      chk("pc_rst", pc_rst, e_pcr);             chk("pc_ld", pc_ld, e_pcld);
      chk("jmp_mode", jmp_mode, e_jm);          chk("jmp_target", jmp_target, e_tgt);
      chk("base_reg_ld", base_reg_ld, e_bld);   chk("base_reg_data", base_reg_data, e_bd);
      chk("ras_count", ras_count, ras_q.size()); chk("ras_ovf", ras_ovf, m_ovf);
      chk("ras_unf", ras_unf, m_unf);
    end
  end

  // Present one fetch beat, then return just after the edge that consumes it.
  task automatic cyc(input bit v, input logic [7:0] i, input logic [7:0] a,
                     input logic [7:0] p, input bit z);
    @(negedge clk);
    in_valid = v; instr = i; arg = a; pc = p; z_flag = z;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pool [20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                            8'h12, 8'h1A, 8'h23, 8'h2F, 8'h40, 8'h41, 8'h42, 8'h43,
                            8'h44, 8'h45, 8'h46, 8'h44};

  initial begin
    rst_n = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0);
    chk("rst in_ready", in_ready, 1);  chk("rst out_valid", out_valid, 0);
    chk("rst alu_op", alu_op, 4'hF);   chk("rst ras_count", ras_count, 0);

    cyc(1, OP_LDI, 8'h5A, 8'h00, 0);
    chk("ldi imm", imm, 8'h5A);        chk("ldi in_b_sel", in_b_sel, 2'b00);
    chk("ldi en_acc", en_acc, 1);      chk("ldi out_valid", out_valid, 1);
    cyc(0, 0, 0, 0, 0);
    chk("idle out_valid", out_valid, 0);

    cyc(1, OP_CALL, 8'h20, 8'h05, 0);
    chk("call1 tgt", jmp_target, 8'h20); chk("call1 cnt", ras_count, 1);
    cyc(1, OP_CALL, 8'h40, 8'h21, 0);
    chk("call2 tgt", jmp_target, 8'h40); chk("call2 cnt", ras_count, 2);
    cyc(1, OP_RET, 8'h00, 8'h41, 0);
    chk("ret1 tgt", jmp_target, 8'h22);  chk("ret1 cnt", ras_count, 1);
    chk("ret1 mode", jmp_mode, 2'b11);
    cyc(1, OP_RET, 8'h00, 8'h23, 0);
    chk("ret2 tgt", jmp_target, 8'h06);  chk("ret2 cnt", ras_count, 0);

    for (int k = 0; k <= DEPTH; k++) cyc(1, OP_CALL, 8'h80 + 8'(k), 8'h10 + 8'(k), 0);
    chk("ovf flag", ras_ovf, 1);       chk("ovf cnt", ras_count, DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      cyc(1, OP_RET, 0, 8'h90, 0);
      if (k == 0) chk("ovf pop1", jmp_target, 8'h15);
    end
    cyc(1, OP_RET, 0, 8'h90, 0);
    chk("unf pc_ld", pc_ld, 0);        chk("unf flag", ras_unf, 1);
    chk("unf valid", out_valid, 1);

    chk("ldar rdy0", in_ready, 1);
    cyc(1, OP_LDAR, 8'h03, 8'h30, 0);
    chk("ldar rdy1", in_ready, 0);     chk("ldar acc1", en_acc, 0);
    chk("ldar mode1", d_mem_addr_mode, 1); chk("ldar sel1", reg_f_sel, 4'h3);
    cyc(1, OP_LDAR, 8'h03, 8'h30, 0);
    chk("ldar rdy2", in_ready, 1);     chk("ldar acc2", en_acc, 1);
    chk("ldar mode2", d_mem_addr_mode, 1); chk("ldar alu2", alu_op, 4'h6);
    cyc(0, 0, 0, 0, 0);

    cyc(1, OP_LDAR, 8'h07, 8'h31, 0);
    rst_n = 0;
    cyc(0, 0, 0, 0, 0);
    chk("ldar rst acc", en_acc, 0);    chk("ldar rst rdy", in_ready, 1);
    rst_n = 1;

    cyc(1, OP_JZ, 8'h10, 8'h50, 0);
    chk("jz0 pc_ld", pc_ld, 0);
    cyc(1, OP_JZ, 8'h10, 8'h51, 1);
    chk("jz1 pc_ld", pc_ld, 1);        chk("jz1 tgt", jmp_target, 8'h10);
    chk("jz1 mode", jmp_mode, 2'b00);

    for (int n = 0; n < 1500; n++) begin
      logic [7:0] op;
      rst_n = ($urandom_range(0, 79) != 0);
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
      cyc($urandom_range(0, 3) != 0, op, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    rst_n = 1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/id_ras.md
Name: id_ras

Overview:
- Registered, handshaked instruction decoder with a parametrised hardware return-address stack (RAS).
- Replaces single-link-register CALL/RET with nested calls up to RAS_DEPTH.
- Executes LDAR as a two-cycle address/data sequence.
- Sits between fetch (instr, arg, pc) and the datapath (ALU, REG_F, DATA_MEM, PC); opcode encodings come from instr_set.v.

Parameters:
- WIDTH, 8, instr/arg/imm/data-address width
- PC_WIDTH, 8, program counter and return-address width
- ALU_INSTR_WIDTH, 4, ALU opcode width
- REG_F_SEL_SIZE, 4, register-file select width (8 regs + PORT)
- IN_B_SEL_SIZE, 2, ALU B-mux select: 00 imm, 01 REG_F, 10 DATA_MEM
- RAS_DEPTH, 4, return-stack entries, at least 2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  fetch presents instr/arg/pc
- in_ready  out  1  decoder accepts this cycle
- instr  in  WIDTH  opcode
- arg  in  WIDTH  operand
- pc  in  PC_WIDTH  address of presented instr
- z_flag  in  1  ALU zero flag
- out_valid  out  1  control outputs valid this cycle
- alu_op  out  ALU_INSTR_WIDTH  ALU operation
- imm  out  WIDTH  immediate
- in_b_sel  out  IN_B_SEL_SIZE  ALU B source
- reg_f_sel  out  REG_F_SEL_SIZE  register select
- en_reg_f  out  1  register write enable
- d_mem_addr  out  WIDTH  data address
- d_mem_addr_mode  out  1  0 operand address, 1 register address
- en_d_mem  out  1  data-memory write enable
- en_acc  out  1  accumulator load
- pc_rst  out  1  PC reset
- pc_ld  out  1  PC load
- jmp_mode  out  2  00 absolute, 01 base-relative, 11 return
- jmp_target  out  PC_WIDTH  absolute target, RAS top or base offset
- base_reg_ld  out  1  base register load
- base_reg_data  out  WIDTH  base register value
- ras_count  out  $clog2(RAS_DEPTH+1)  live entries
- ras_ovf  out  1  sticky overflow
- ras_unf  out  1  sticky underflow

Behaviour:
- All outputs registered.
- Idle/default values:
  - alu_op = all ones
  - in_b_sel = 2'b10
  - all other outputs 0
  - out_valid = 0
- Reset (rst_n = 0 at clk edge):
  - all outputs take default values
  - ras_count = 0, ras_ovf = 0, ras_unf = 0
  - FSM goes to S_RUN
  - in_ready = 1 after reset is released
  - Reset during S_LDAR2 abandons the sequence with no en_acc pulse.
- FSM states: S_RUN, S_LDAR2.
  - in_ready = 1 only in S_RUN.
- Accept = in_valid && in_ready.
  - Decoded controls appear on the next edge with out_valid = 1.
  - Latency: 1 cycle.
  - No accept: out_valid = 0 and all enables 0.
- Opcode decode (all others: NOP pulse with out_valid = 1, enables 0):
  - LD, ALU ops, ST, LDR/STR, register ALU ops, LDI, BAR, JMP/JMPO: same control sets as the current single-cycle decoder.
  - Jumps drive jmp_target = arg[PC_WIDTH-1:0].
  - z_flag is sampled at accept.
  - JZ/JZO with z_flag = 0: NOP.
- CALL:
  - push pc+1, mod 2^PC_WIDTH
  - jmp_mode = 00, jmp_target = arg, pc_ld = 1
- CALL when full:
  - push still occurs; oldest entry is overwritten (circular)
  - ras_count stays at RAS_DEPTH
  - ras_ovf set
- RET, non-empty: pop; jmp_mode = 11, jmp_target = popped entry, pc_ld = 1.
- RET, empty: ras_unf set, pc_ld = 0, NOP pulse.
- RST: pc_rst = 1 pulse; RAS cleared (count 0); sticky flags retained.
- LDAR:
  - Cycle 1 output: reg_f_sel = arg[3:0], d_mem_addr_mode = 1, en_acc = 0, out_valid = 1; FSM goes to S_LDAR2.
  - Cycle 2 output: same select values plus en_acc = 1, alu_op = LDAR low bits, in_b_sel = 10; FSM returns to S_RUN.
  - in_ready = 0 during S_LDAR2.
- Sticky flags clear only on rst_n.

Test Plan:
- Reset with rst_n low 2 cycles -> in_ready = 1, out_valid = 0, alu_op = 4'hF, ras_count = 0 after release.
- LDI arg = 8'h5A accepted -> next cycle imm = 8'h5A, in_b_sel = 00, en_acc = 1, out_valid = 1; no accept -> out_valid = 0.
- CALL 8'h20 at pc 8'h05, CALL 8'h40 at pc 8'h21, then RET, RET:
  - jmp_target sequence: 20, 40, 22, 06
  - ras_count sequence: 1, 2, 1, 0
- RAS_DEPTH+1 CALLs, then RET with RAS empty:
  - ras_ovf = 1 after the last CALL
  - the RET with RAS empty pulses pc_ld = 0 and sets ras_unf
- LDAR arg = 8'h03, in_valid held high:
  - in_ready pattern: 1, 0, 1
  - en_acc = 0 then 1; d_mem_addr_mode = 1 both cycles
  - rst_n low in S_LDAR2 -> no en_acc pulse.
- JZ 8'h10 with z_flag = 0 -> pc_ld = 0; with z_flag = 1 -> pc_ld = 1, jmp_target = 8'h10, jmp_mode = 00.
